// File: rtl/dcache_sram_assoc_pkg.sv
// D-cache shared constants: default geometry, flush FSM encoding
// and a width helper used by the cache and its LRU sub-module.
package dcache_sram_assoc_pkg;

   localparam int DC_WAYS        = 2;
   localparam int DC_IDX_W       = 1;
   localparam int DC_TAG_W       = 3;
   localparam int DC_BLOCK_BYTES = 4;

   typedef enum logic [1:0] {
      FL_IDLE  = 2'd0,
      FL_SCAN  = 2'd1,
      FL_EVICT = 2'd2
   } flush_state_t;

   // Way-index / LRU-age width; a 1-way cache still gets one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dcache_sram_assoc_if.sv
// D-cache CPU/memory-side bundle: lookup, write, refill, flush.
// master drives requests; slave (the cache) drives results.
interface dcache_sram_assoc_if
   import dcache_sram_assoc_pkg::*;
#(
   parameter int TAG_W       = DC_TAG_W,
   parameter int IDX_W       = DC_IDX_W,
   parameter int BLOCK_BYTES = DC_BLOCK_BYTES
);
   logic                     ren;
   logic                     wen;
   logic                     memWen;
   logic [BLOCK_BYTES-1:0]   bytesAccess;
   logic [TAG_W+IDX_W-1:0]   blockAddr;
   logic [8*BLOCK_BYTES-1:0] dataIn;
   logic                     flushReq;
   logic                     evictReady;
   logic                     hit;
   logic                     dirtyBit;
   logic [8*BLOCK_BYTES-1:0] dataOut;
   logic [TAG_W+IDX_W-1:0]   victimAddr;
   logic                     evictValid;
   logic                     busy;
   logic                     flushDone;

   modport master (
      output ren, wen, memWen, bytesAccess, blockAddr,
             dataIn, flushReq, evictReady,
      input  hit, dirtyBit, dataOut, victimAddr,
             evictValid, busy, flushDone
   );

   modport slave (
      input  ren, wen, memWen, bytesAccess, blockAddr,
             dataIn, flushReq, evictReady,
      output hit, dirtyBit, dataOut, victimAddr,
             evictValid, busy, flushDone
   );
endinterface

// File: rtl/dcache_sram_assoc_lru.sv
// Per-set LRU ages (0 = most recent). Ports: set_idx selects the set
// read on ages and updated on touch; touch_way becomes age 0.
module dcache_lru
   import dcache_sram_assoc_pkg::*;
#(
   parameter int WAYS  = DC_WAYS,
   parameter int IDX_W = DC_IDX_W,
   localparam int AGE_W = clog2_min1(WAYS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [IDX_W-1:0]            set_idx,
   input  logic                        touch,
   input  logic [AGE_W-1:0]            touch_way,
   output logic [WAYS-1:0][AGE_W-1:0]  ages
);
   localparam int SETS = 2**IDX_W;

   logic [WAYS-1:0][AGE_W-1:0] age_q [SETS];
   logic [WAYS-1:0][AGE_W-1:0] age_d [SETS];
   logic [AGE_W-1:0]           old_age;

   assign ages = age_q[set_idx];

   always_comb begin
      age_d   = age_q;
      old_age = age_q[set_idx][touch_way];
      if (touch) begin
         for (int v = 0; v < WAYS; v++) begin
            if (AGE_W'(v) == touch_way)
               age_d[set_idx][v] = '0;
            else if (age_q[set_idx][v] < old_age)
               age_d[set_idx][v] = age_q[set_idx][v] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= AGE_W'(w);
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/dcache_sram_assoc.sv
// Set-associative D-cache array with byte writes, LRU refill and a
// flush engine. Ports: clk, rst (async active-low), bus (slave).
module dcache_sram_assoc
   import dcache_sram_assoc_pkg::*;
#(
   parameter int WAYS        = DC_WAYS,
   parameter int IDX_W       = DC_IDX_W,
   parameter int TAG_W       = DC_TAG_W,
   parameter int BLOCK_BYTES = DC_BLOCK_BYTES
) (
   input logic                clk,
   input logic                rst,
   dcache_sram_assoc_if.slave bus
);
   localparam int SETS   = 2**IDX_W;
   localparam int BLK_W  = 8*BLOCK_BYTES;
   localparam int ADDR_W = TAG_W+IDX_W;
   localparam int WAY_W  = clog2_min1(WAYS);

   flush_state_t     state_q, state_d;
   logic [IDX_W-1:0] scan_set_q, scan_set_d, nxt_set;
   logic [WAY_W-1:0] scan_way_q, scan_way_d, nxt_way;
   logic             last_entry;
   logic             flush_done_q, flush_done_d;

   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  valid_d [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   logic [WAYS-1:0]  dirty_d [SETS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [TAG_W-1:0] tag_d   [SETS][WAYS];
   logic [BLK_W-1:0] data_q  [SETS][WAYS];
   logic [BLK_W-1:0] data_d  [SETS][WAYS];

   logic [IDX_W-1:0]           idx;
   logic [TAG_W-1:0]           tag;
   logic                       match_any, inv_any;
   logic [WAY_W-1:0]           hit_way, vic_way;
   logic [WAY_W-1:0]           best_age;
   logic [WAYS-1:0][WAY_W-1:0] ages;
   logic                       busy, touch;
   logic [WAY_W-1:0]           touch_way;
   logic [BLK_W-1:0]           data_out;
   logic [ADDR_W-1:0]          victim_addr;

   assign idx = bus.blockAddr[IDX_W-1:0];
   assign tag = bus.blockAddr[ADDR_W-1:IDX_W];

   dcache_lru #(.WAYS(WAYS), .IDX_W(IDX_W)) u_lru (
      .clk       (clk),
      .rst       (rst),
      .set_idx   (idx),
      .touch     (touch),
      .touch_way (touch_way),
      .ages      (ages)
   );

   always_comb begin
      match_any = 1'b0;
      hit_way   = '0;
      inv_any   = 1'b0;
      vic_way   = '0;
      best_age  = ages[0];
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag && !match_any) begin
            match_any = 1'b1;
            hit_way   = WAY_W'(w);
         end
         if (!valid_q[idx][w] && !inv_any) begin
            inv_any = 1'b1;
            vic_way = WAY_W'(w);
         end
      end
      // Ages form a permutation, so the strict maximum is unique.
      if (!inv_any) begin
         for (int w = 1; w < WAYS; w++) begin
            if (ages[w] > best_age) begin
               best_age = ages[w];
               vic_way  = WAY_W'(w);
            end
         end
      end
   end

   assign busy           = (state_q != FL_IDLE);
   assign bus.busy       = busy;
   assign bus.evictValid = (state_q == FL_EVICT);
   assign bus.flushDone  = flush_done_q;
   assign bus.hit        = !busy && match_any;
   assign bus.dirtyBit   = !busy && !match_any &&
                           valid_q[idx][vic_way] && dirty_q[idx][vic_way];
   assign bus.dataOut    = data_out;
   assign bus.victimAddr = victim_addr;

   always_comb begin
      if (state_q == FL_EVICT) begin
         data_out    = data_q[scan_set_q][scan_way_q];
         victim_addr = {tag_q[scan_set_q][scan_way_q], scan_set_q};
      end else begin
         data_out    = match_any ? data_q[idx][hit_way]
                                 : data_q[idx][vic_way];
         victim_addr = {tag_q[idx][vic_way], idx};
      end
   end

   always_comb begin
      last_entry = (scan_set_q == IDX_W'(SETS-1)) &&
                   (scan_way_q == WAY_W'(WAYS-1));
      if (scan_way_q == WAY_W'(WAYS-1)) begin
         nxt_way = '0;
         nxt_set = scan_set_q + 1'b1;
      end else begin
         nxt_way = scan_way_q + 1'b1;
         nxt_set = scan_set_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      scan_set_d   = scan_set_q;
      scan_way_d   = scan_way_q;
      flush_done_d = 1'b0;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      tag_d        = tag_q;
      data_d       = data_q;
      touch        = 1'b0;
      touch_way    = hit_way;
      unique case (state_q)
         FL_IDLE: begin
            if (bus.memWen) begin
               valid_d[idx][vic_way] = 1'b1;
               dirty_d[idx][vic_way] = 1'b0;
               tag_d[idx][vic_way]   = tag;
               data_d[idx][vic_way]  = bus.dataIn;
               touch                 = 1'b1;
               touch_way             = vic_way;
            end else if (bus.wen) begin
               if (match_any) begin
                  for (int b = 0; b < BLOCK_BYTES; b++)
                     if (bus.bytesAccess[b])
                        data_d[idx][hit_way][b*8 +: 8] = bus.dataIn[b*8 +: 8];
                  dirty_d[idx][hit_way] = 1'b1;
                  touch                 = 1'b1;
               end
            end else if (bus.ren && match_any) begin
               touch = 1'b1;
            end
            if (bus.flushReq) state_d = FL_SCAN;
         end
         FL_SCAN: begin
            if (valid_q[scan_set_q][scan_way_q] &&
                dirty_q[scan_set_q][scan_way_q]) begin
               state_d = FL_EVICT;
            end else if (last_entry) begin
               state_d      = FL_IDLE;
               flush_done_d = 1'b1;
               scan_set_d   = '0;
               scan_way_d   = '0;
            end else begin
               scan_set_d = nxt_set;
               scan_way_d = nxt_way;
            end
         end
         FL_EVICT: begin
            if (bus.evictReady) begin
               dirty_d[scan_set_q][scan_way_q] = 1'b0;
               if (last_entry) begin
                  state_d      = FL_IDLE;
                  flush_done_d = 1'b1;
                  scan_set_d   = '0;
                  scan_way_d   = '0;
               end else begin
                  state_d    = FL_SCAN;
                  scan_set_d = nxt_set;
                  scan_way_d = nxt_way;
               end
            end
         end
         default: state_d = FL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= FL_IDLE;
         scan_set_q   <= '0;
         scan_way_q   <= '0;
         flush_done_q <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               data_q[s][w] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         scan_set_q   <= scan_set_d;
         scan_way_q   <= scan_way_d;
         flush_done_q <= flush_done_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         tag_q        <= tag_d;
         data_q       <= data_d;
      end
   end

endmodule

// File: tb/tb_dcache_sram_assoc.sv
// Self-checking bench for dcache_sram_assoc (default geometry).
// Expected lookups/evictions are queued, then popped on DUT output.
module tb_dcache_sram_assoc;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_sram_assoc_if bus ();
   dcache_sram_assoc dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      string       name;
      logic        hit;
      logic        dirty;
      logic [31:0] data;
      logic        chk_data;
      logic [3:0]  va;
      logic        chk_va;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.ren         = 1'b0;
      bus.wen         = 1'b0;
      bus.memWen      = 1'b0;
      bus.bytesAccess = '0;
      bus.blockAddr   = '0;
      bus.dataIn      = '0;
      bus.flushReq    = 1'b0;
      bus.evictReady  = 1'b0;
   endtask

   task automatic memwen(input logic [3:0] a, input logic [31:0] d);
      bus.memWen = 1'b1; bus.blockAddr = a; bus.dataIn = d;
      cycle();
      bus.memWen = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] be,
                     input logic [31:0] d);
      bus.wen = 1'b1; bus.blockAddr = a;
      bus.bytesAccess = be; bus.dataIn = d;
      cycle();
      bus.wen = 1'b0;
   endtask

   task automatic look(input string nm, input logic [3:0] a,
                       input logic eh, input logic ed,
                       input logic cd, input logic [31:0] edata,
                       input logic cv, input logic [3:0] eva);
      exp_t e, g;
      e.name = nm; e.hit = eh; e.dirty = ed; e.chk_data = cd;
      e.data = edata; e.chk_va = cv; e.va = eva;
      sb.push_back(e);
      bus.ren = 1'b1; bus.blockAddr = a;
      @(negedge clk);
      g = sb.pop_front();
      n_cmp++;
      if (bus.hit !== g.hit) begin
         n_bad++;
         $display("FAIL %s hit: got %b want %b", g.name, bus.hit, g.hit);
      end
      n_cmp++;
      if (bus.dirtyBit !== g.dirty) begin
         n_bad++;
         $display("FAIL %s dirtyBit: got %b want %b", g.name, bus.dirtyBit, g.dirty);
      end
      if (g.chk_data) begin
         n_cmp++;
         if (bus.dataOut !== g.data) begin
            n_bad++;
            $display("FAIL %s dataOut: got %h want %h", g.name, bus.dataOut, g.data);
         end
      end
      if (g.chk_va) begin
         n_cmp++;
         if (bus.victimAddr !== g.va) begin
            n_bad++;
            $display("FAIL %s victimAddr: got %b want %b", g.name, bus.victimAddr, g.va);
         end
      end
      cycle();
      bus.ren = 1'b0;
   endtask

   task automatic push_evict(input string nm, input logic [3:0] va,
                             input logic [31:0] d);
      exp_t e;
      e.name = nm; e.hit = 1'b0; e.dirty = 1'b0; e.chk_data = 1'b1;
      e.data = d; e.chk_va = 1'b1; e.va = va;
      sb.push_back(e);
   endtask

   task automatic check_evict(input exp_t g, input string tag_s);
      n_cmp++;
      if (bus.evictValid !== 1'b1 || bus.dataOut !== g.data ||
          bus.victimAddr !== g.va) begin
         n_bad++;
         $display("FAIL %s %s: got v=%b %b/%h want v=1 %b/%h", g.name, tag_s,
                  bus.evictValid, bus.victimAddr, bus.dataOut, g.va, g.data);
      end
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b0;
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      bus.ren = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.evictValid, bus.flushDone} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_status: got %b want 000",
                  {bus.busy, bus.evictValid, bus.flushDone});
      end
      cycle();
      look("reset_lookup", 4'b0000, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_fill();
      memwen(4'b0000, 32'hFFFF_FFFF);
      look("fill_hit", 4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, '0);
   endtask

   task automatic test_byte_write();
      wr(4'b0000, 4'b0001, 32'h0000_00AA);
      look("bytewr_hit", 4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFAA, 1'b0, '0);
      wr(4'b0001, 4'b1111, 32'h1234_5678);
      look("wen_miss", 4'b0001, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_victim();
      memwen(4'b0010, 32'h1111_1111);
      look("lru_touch0", 4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFAA, 1'b0, '0);
      look("victim_lru", 4'b0100, 1'b0, 1'b0, 1'b1, 32'h1111_1111,
           1'b1, 4'b0010);
      memwen(4'b0100, 32'h2222_2222);
      look("keep_tag0", 4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFAA, 1'b0, '0);
      look("refill_hit", 4'b0100, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 1'b0, '0);
      look("evicted_001", 4'b0010, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_dirty_miss();
      look("dirty_miss", 4'b0110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFAA,
           1'b1, 4'b0000);
      look("dirty_miss2", 4'b0110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFAA,
           1'b1, 4'b0000);
      wr(4'b0100, 4'b1010, 32'hAABB_CCDD);
      look("mask_1010", 4'b0100, 1'b1, 1'b0, 1'b1, 32'hAA22_CC22, 1'b0, '0);
   endtask

   task automatic test_flush();
      exp_t g;
      int   n;
      int   extra;
      logic seen;
      push_evict("evict0", 4'b0000, 32'hFFFF_FFAA);
      push_evict("evict1", 4'b0100, 32'hAA22_CC22);
      bus.flushReq = 1'b1;
      cycle();
      bus.flushReq = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n = 0;
         while (!bus.evictValid && n < 20) begin
            @(negedge clk);
            n++;
         end
         g = sb.pop_front();
         check_evict(g, "present");
         if (k == 0) begin
            bus.ren = 1'b1; bus.blockAddr = 4'b0000;
            bus.wen = 1'b1; bus.bytesAccess = 4'b1111; bus.dataIn = '0;
            bus.flushReq = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check_evict(g, "hold");
               n_cmp++;
               if (bus.hit !== 1'b0 || bus.busy !== 1'b1) begin
                  n_bad++;
                  $display("FAIL busy_ignore: got hit=%b busy=%b want hit=0 busy=1",
                           bus.hit, bus.busy);
               end
            end
         end
         @(posedge clk);
         #1;
         bus.ren = 1'b0; bus.wen = 1'b0; bus.flushReq = 1'b0;
         bus.evictReady = 1'b1;
         cycle();
         bus.evictReady = 1'b0;
      end
      n = 0; extra = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         if (bus.flushDone) seen = 1'b1;
         else if (bus.evictValid) extra++;
         n++;
      end
      n_cmp++;
      if (seen !== 1'b1 || bus.busy !== 1'b0 || extra != 0) begin
         n_bad++;
         $display("FAIL flush_done: got done=%b busy=%b extra=%0d want 1 0 0",
                  seen, bus.busy, extra);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.flushDone !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse: got %b want 0", bus.flushDone);
      end
      cycle();
      look("post_flush0", 4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFAA, 1'b0, '0);
      look("post_flush1", 4'b0100, 1'b1, 1'b0, 1'b1, 32'hAA22_CC22, 1'b0, '0);
      look("post_clean", 4'b0110, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_reset_evict();
      exp_t g;
      int   n;
      int   pulses;
      memwen(4'b1011, 32'h3333_3333);
      wr(4'b1011, 4'b1111, 32'h4444_4444);
      push_evict("evict_set1", 4'b1011, 32'h4444_4444);
      bus.flushReq = 1'b1;
      cycle();
      bus.flushReq = 1'b0;
      @(negedge clk);
      n = 0;
      while (!bus.evictValid && n < 20) begin
         @(negedge clk);
         n++;
      end
      g = sb.pop_front();
      check_evict(g, "present");
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.evictValid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_abort: got busy=%b ev=%b want 0 0",
                  bus.busy, bus.evictValid);
      end
      cycle();
      rst = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.flushDone) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++;
         $display("FAIL rst_no_done: got %0d pulses want 0", pulses);
      end
      cycle();
      look("rst_inval1", 4'b1011, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      look("rst_inval0", 4'b0000, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_byte_write();
      test_victim();
      test_dirty_miss();
      test_flush();
      test_reset_evict();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
